// File: rtl/dmem_responder_if.sv
// Data-memory request/response channel between an LSU initiator and the dmem_responder.
// The master modport is the initiator side, the slave modport is the responder side.
interface dmem_responder_if;
   logic        req_valid_i;
   logic        req_ready_o;
   logic        req_we_i;
   logic [31:0] req_addr_i;
   logic [31:0] req_wdata_i;
   logic [2:0]  req_size_i;
   logic        rsp_valid_o;
   logic        rsp_ready_i;
   logic [31:0] rsp_rdata_o;
   logic        rsp_err_o;

   modport master (
      output req_valid_i, req_we_i, req_addr_i, req_wdata_i, req_size_i, rsp_ready_i,
      input  req_ready_o, rsp_valid_o, rsp_rdata_o, rsp_err_o
   );

   modport slave (
      input  req_valid_i, req_we_i, req_addr_i, req_wdata_i, req_size_i, rsp_ready_i,
      output req_ready_o, rsp_valid_o, rsp_rdata_o, rsp_err_o
   );
endinterface

// File: rtl/dmem_responder.sv
// Data-memory responder: one load/store per handshake, WAIT_CYCLES access latency, RV32I lane
// steering and load extension. Optional macro DMEM_MISALIGN_CHK_EN turns misaligned H/W into errors.
module dmem_responder #(
   parameter int unsigned DEPTH_WORDS = 1024,
   parameter logic [31:0] BASE_ADDR   = 32'h0000_2000,
   parameter int unsigned WAIT_CYCLES = 1
) (
   input logic              clk,
   input logic              rst,
   dmem_responder_if.slave  bus
);
   localparam int unsigned AW        = $clog2(DEPTH_WORDS);
   localparam logic [32:0] WIN_BYTES = 33'(DEPTH_WORDS) << 2;
   localparam logic [3:0]  WAIT_INIT = 4'(WAIT_CYCLES);

   typedef enum logic [1:0] {
      ST_IDLE   = 2'd0,
      ST_WAIT   = 2'd1,
      ST_ACCESS = 2'd2,
      ST_RESP   = 2'd3
   } state_t;

   state_t      state_r;
   state_t      state_nxt_s;
   logic        ready_r;
   logic [3:0]  wait_cnt_r;
   logic        we_r;
   logic [31:0] addr_r;
   logic [31:0] wdata_r;
   logic [2:0]  size_r;
   logic        rsp_valid_r;
   logic [31:0] rsp_rdata_r;
   logic        rsp_err_r;

   logic [31:0] mem [DEPTH_WORDS];

   logic        accept_s;
   logic [31:0] off_s;
   logic        in_win_s;
   logic        size_ok_s;
   logic        misalign_s;
   logic        err_s;
   logic [AW-1:0] idx_s;
   logic [31:0] word_s;
   logic [31:0] load_val_s;
   logic [3:0]  be_s;
   logic [31:0] st_data_s;
   logic        mem_wr_s;

   // Pick the addressed byte/half and apply sign or zero extension.
   function automatic logic [31:0] load_extend(input logic [31:0] word,
                                               input logic [2:0]  size,
                                               input logic [1:0]  lane);
      logic [7:0]  b;
      logic [15:0] h;
      logic [31:0] res;
      case (lane)
         2'd0:    b = word[7:0];
         2'd1:    b = word[15:8];
         2'd2:    b = word[23:16];
         2'd3:    b = word[31:24];
         default: b = 8'd0;
      endcase
      h = lane[1] ? word[31:16] : word[15:0];
      case (size)
         3'b000:  res = {{24{b[7]}}, b};
         3'b001:  res = {{16{h[15]}}, h};
         3'b010:  res = word;
         3'b100:  res = {24'd0, b};
         3'b101:  res = {16'd0, h};
         default: res = 32'd0;
      endcase
      return res;
   endfunction

   function automatic logic [3:0] store_be(input logic [2:0] size, input logic [1:0] lane);
      logic [3:0] be;
      case (size)
         3'b000:  be = 4'b0001 << lane;
         3'b001:  be = lane[1] ? 4'b1100 : 4'b0011;
         3'b010:  be = 4'b1111;
         default: be = 4'b0000;
      endcase
      return be;
   endfunction

   assign accept_s = (state_r == ST_IDLE) && bus.req_valid_i && ready_r;

   // Next-state logic.
   always_comb begin
      state_nxt_s = state_r;
      case (state_r)
         ST_IDLE: begin
            if (accept_s) begin
               if (WAIT_CYCLES > 32'd0) state_nxt_s = ST_WAIT;
               else                     state_nxt_s = ST_ACCESS;
            end else begin
               state_nxt_s = ST_IDLE;
            end
         end
         ST_WAIT: begin
            if (wait_cnt_r <= 4'd1) state_nxt_s = ST_ACCESS;
            else                    state_nxt_s = ST_WAIT;
         end
         ST_ACCESS: state_nxt_s = ST_RESP;
         ST_RESP: begin
            if (bus.rsp_ready_i) state_nxt_s = ST_IDLE;
            else                 state_nxt_s = ST_RESP;
         end
         default: state_nxt_s = ST_IDLE;
      endcase
   end

   // Decode the latched request: window, size legality, alignment, lane data.
   always_comb begin
      off_s      = addr_r - BASE_ADDR;
      in_win_s   = {1'b0, off_s} < WIN_BYTES;
      idx_s      = off_s[AW+1:2];
      if (we_r) begin
         size_ok_s = (size_r == 3'b000) || (size_r == 3'b001) || (size_r == 3'b010);
      end else begin
         size_ok_s = (size_r == 3'b000) || (size_r == 3'b001) || (size_r == 3'b010) ||
                     (size_r == 3'b100) || (size_r == 3'b101);
      end
`ifdef DMEM_MISALIGN_CHK_EN
      misalign_s = ((size_r[1:0] == 2'b01) && addr_r[0]) ||
                   ((size_r[1:0] == 2'b10) && (addr_r[1:0] != 2'b00));
`else
      misalign_s = 1'b0;
`endif
      err_s      = !in_win_s || !size_ok_s || misalign_s;
      word_s     = mem[idx_s];
      load_val_s = load_extend(word_s, size_r, addr_r[1:0]);
      be_s       = store_be(size_r, addr_r[1:0]);
      case (size_r)
         3'b000:  st_data_s = {4{wdata_r[7:0]}};
         3'b001:  st_data_s = {2{wdata_r[15:0]}};
         default: st_data_s = wdata_r;
      endcase
      mem_wr_s   = (state_r == ST_ACCESS) && we_r && !err_s && !rst;
   end

   // RAM array: lane-masked writes, contents survive reset.
   always_ff @(posedge clk) begin
      if (mem_wr_s) begin
         for (int i = 0; i < 4; i++) begin
            if (be_s[i]) mem[idx_s][8*i +: 8] <= st_data_s[8*i +: 8];
         end
      end
   end

   // State, request latch, wait counter and registered response.
   always_ff @(posedge clk) begin
      if (rst) begin
         state_r     <= ST_IDLE;
         ready_r     <= 1'b0;
         wait_cnt_r  <= 4'd0;
         we_r        <= 1'b0;
         addr_r      <= 32'd0;
         wdata_r     <= 32'd0;
         size_r      <= 3'd0;
         rsp_valid_r <= 1'b0;
         rsp_rdata_r <= 32'd0;
         rsp_err_r   <= 1'b0;
      end else begin
         state_r <= state_nxt_s;
         ready_r <= (state_nxt_s == ST_IDLE);
         if (accept_s) begin
            we_r       <= bus.req_we_i;
            addr_r     <= bus.req_addr_i;
            wdata_r    <= bus.req_wdata_i;
            size_r     <= bus.req_size_i;
            wait_cnt_r <= WAIT_INIT;
         end else if (state_r == ST_WAIT) begin
            wait_cnt_r <= wait_cnt_r - 4'd1;
         end
         if (state_r == ST_ACCESS) begin
            rsp_valid_r <= 1'b1;
            rsp_err_r   <= err_s;
            rsp_rdata_r <= (err_s || we_r) ? 32'd0 : load_val_s;
         end else if ((state_r == ST_RESP) && bus.rsp_ready_i) begin
            rsp_valid_r <= 1'b0;
            rsp_err_r   <= 1'b0;
            rsp_rdata_r <= 32'd0;
         end
      end
   end

   assign bus.req_ready_o = ready_r;
   assign bus.rsp_valid_o = rsp_valid_r;
   assign bus.rsp_rdata_o = rsp_rdata_r;
   assign bus.rsp_err_o   = rsp_err_r;
endmodule

// File: tb/tb_dmem_responder.sv
// Scoreboard bench for dmem_responder: a byte-addressed reference model predicts each response,
// which is queued at request time and compared when the responder answers.
module tb_dmem_responder;
   localparam int unsigned DEPTH = 1024;
   localparam logic [31:0] BASE  = 32'h0000_2000;
   localparam int unsigned WAITC = 1;

   typedef struct packed {
      logic [31:0] rdata;
      logic        err;
   } exp_t;

   logic clk = 1'b0;
   logic rst = 1'b1;
   int   cyc = 0;
   int   n_chk = 0;
   int   n_pass = 0;
   exp_t exp_q[$];
   logic [7:0] ref_mem [logic [31:0]];

   dmem_responder_if bus ();

   dmem_responder #(.DEPTH_WORDS(DEPTH), .BASE_ADDR(BASE), .WAIT_CYCLES(WAITC)) dut (
      .clk (clk),
      .rst (rst),
      .bus (bus)
   );

   always #5 clk = ~clk;
   always @(posedge clk) cyc <= cyc + 1;

   initial begin
      #500000;
      $display("FAIL watchdog: got timeout expected finish");
      $fatal(1, "watchdog");
   end

   task automatic check_val(input string tag, input logic [31:0] obs, input logic [31:0] exp);
      n_chk++;
      if (obs !== exp) $display("FAIL %s: got %h expected %h", tag, obs, exp);
      else             n_pass++;
   endtask

   // Reference model: byte memory, little-endian, independent of RTL structure.
   task automatic predict(input logic we, input logic [31:0] addr, input logic [31:0] wdata,
                          input logic [2:0] size, output logic [31:0] rd, output logic err);
      logic [31:0] off;
      logic [31:0] a;
      logic [31:0] v;
      int          nb;
      bit          bad;
      off = addr - BASE;
      bad = (off >= 32'(DEPTH * 4));
      if (we) bad = bad || !(size inside {3'b000, 3'b001, 3'b010});
      else    bad = bad || !(size inside {3'b000, 3'b001, 3'b010, 3'b100, 3'b101});
`ifdef DMEM_MISALIGN_CHK_EN
      if ((size == 3'b001 || size == 3'b101) && addr[0]) bad = 1'b1;
      if (size == 3'b010 && addr[1:0] != 2'b00) bad = 1'b1;
`endif
      nb = (size[1:0] == 2'b00) ? 1 : (size[1:0] == 2'b01) ? 2 : 4;
      a  = addr & ~(32'(nb) - 32'd1);
      rd = 32'd0;
      err = bad;
      if (!bad && we) begin
         for (int i = 0; i < nb; i++) ref_mem[a + 32'(i)] = wdata[8*i +: 8];
      end else if (!bad) begin
         v = 32'd0;
         for (int i = 0; i < nb; i++) v[8*i +: 8] = ref_mem[a + 32'(i)];
         if (!size[2] && nb == 1) v = {{24{v[7]}}, v[7:0]};
         if (!size[2] && nb == 2) v = {{16{v[15]}}, v[15:0]};
         rd = v;
      end
   endtask

   task automatic do_txn(input logic we, input logic [31:0] addr, input logic [31:0] wdata,
                         input logic [2:0] size, input int hold, input bit early_rdy);
      exp_t e;
      int   n;
      int   acc_cyc;
      int   rsp_cyc;
      @(negedge clk);
      bus.req_valid_i = 1'b1;
      bus.req_we_i    = we;
      bus.req_addr_i  = addr;
      bus.req_wdata_i = wdata;
      bus.req_size_i  = size;
      n = 0;
      while (!bus.req_ready_o && n < 20) begin
         @(negedge clk);
         n++;
      end
      if (n >= 20) check_val("accept_timeout", 32'd1, 32'd0);
      acc_cyc = cyc;
      predict(we, addr, wdata, size, e.rdata, e.err);
      exp_q.push_back(e);
      @(posedge clk);
      #1;
      bus.req_valid_i = 1'b0;
      bus.req_addr_i  = 32'hFFFF_FFFF;
      bus.rsp_ready_i = early_rdy;
      n = 0;
      do begin
         @(negedge clk);
         n++;
      end while (!bus.rsp_valid_o && n < 40);
      rsp_cyc = cyc;
      e = exp_q.pop_front();
      check_val("rsp_valid", 32'(bus.rsp_valid_o), 32'd1);
      check_val("latency", 32'(rsp_cyc - acc_cyc), 32'(WAITC + 2));
      check_val("rdata", bus.rsp_rdata_o, e.rdata);
      check_val("err", 32'(bus.rsp_err_o), 32'(e.err));
      for (int i = 0; i < hold; i++) begin
         @(negedge clk);
         check_val("hold_valid", 32'(bus.rsp_valid_o), 32'd1);
         check_val("hold_rdata", bus.rsp_rdata_o, e.rdata);
         check_val("hold_ready", 32'(bus.req_ready_o), 32'd0);
      end
      bus.rsp_ready_i = 1'b1;
      @(posedge clk);
      #1;
      bus.rsp_ready_i = 1'b0;
      check_val("rsp_drop", 32'(bus.rsp_valid_o), 32'd0);
      check_val("idle_ready", 32'(bus.req_ready_o), 32'd1);
   endtask

   // Store that is cut off by reset `d` cycles after its accept edge: RAM must stay untouched.
   task automatic store_then_reset(input logic [31:0] addr, input logic [31:0] wdata, input int d);
      int n;
      @(negedge clk);
      bus.req_valid_i = 1'b1;
      bus.req_we_i    = 1'b1;
      bus.req_addr_i  = addr;
      bus.req_wdata_i = wdata;
      bus.req_size_i  = 3'b010;
      n = 0;
      while (!bus.req_ready_o && n < 20) begin
         @(negedge clk);
         n++;
      end
      @(posedge clk);
      #1;
      bus.req_valid_i = 1'b0;
      repeat (d) begin
         @(posedge clk);
         #1;
      end
      rst = 1'b1;
      @(posedge clk);
      #1;
      rst = 1'b0;
      check_val("rst_mid_valid", 32'(bus.rsp_valid_o), 32'd0);
      check_val("rst_mid_ready", 32'(bus.req_ready_o), 32'd0);
   endtask

   logic [2:0]  size_tab [5];
   logic [31:0] wd;
   int          idx;

   initial begin
      size_tab[0] = 3'b000; size_tab[1] = 3'b001; size_tab[2] = 3'b100;
      size_tab[3] = 3'b101; size_tab[4] = 3'b010;
      bus.req_valid_i = 1'b0;
      bus.req_we_i    = 1'b0;
      bus.req_addr_i  = 32'd0;
      bus.req_wdata_i = 32'd0;
      bus.req_size_i  = 3'd0;
      bus.rsp_ready_i = 1'b0;

      repeat (2) @(posedge clk);
      @(negedge clk);
      check_val("rst_ready", 32'(bus.req_ready_o), 32'd0);
      check_val("rst_valid", 32'(bus.rsp_valid_o), 32'd0);
      check_val("rst_rdata", bus.rsp_rdata_o, 32'd0);
      check_val("rst_err", 32'(bus.rsp_err_o), 32'd0);
      rst = 1'b0;
      @(posedge clk);
      @(negedge clk);
      check_val("rel_ready", 32'(bus.req_ready_o), 32'd1);

      do_txn(1'b1, 32'h2000, 32'hDEAD_BEEF, 3'b010, 0, 1'b0);
      do_txn(1'b0, 32'h2000, 32'd0, 3'b010, 0, 1'b0);

      do_txn(1'b1, 32'h2000, 32'h1122_3344, 3'b010, 0, 1'b0);
      do_txn(1'b1, 32'h2003, 32'hAAAA_AA80, 3'b000, 0, 1'b0);
      do_txn(1'b0, 32'h2003, 32'd0, 3'b000, 0, 1'b0);
      do_txn(1'b0, 32'h2003, 32'd0, 3'b100, 0, 1'b0);
      do_txn(1'b0, 32'h2000, 32'd0, 3'b010, 0, 1'b0);
      do_txn(1'b0, 32'h2002, 32'd0, 3'b001, 0, 1'b0);
      do_txn(1'b0, 32'h2002, 32'd0, 3'b101, 0, 1'b0);
      do_txn(1'b1, 32'h2006, 32'h0000_BEEF, 3'b001, 0, 1'b1);
      do_txn(1'b0, 32'h2004, 32'd0, 3'b101, 0, 1'b0);

      do_txn(1'b1, 32'h2FFC, 32'hA5A5_5A5A, 3'b010, 0, 1'b0);
      do_txn(1'b0, 32'h2FFC, 32'd0, 3'b010, 0, 1'b0);
      do_txn(1'b0, 32'h1FFC, 32'd0, 3'b010, 0, 1'b0);
      do_txn(1'b0, BASE + 32'(4 * DEPTH), 32'd0, 3'b010, 0, 1'b0);
      do_txn(1'b1, 32'h1FFC, 32'h5555_5555, 3'b010, 0, 1'b0);
      do_txn(1'b1, BASE + 32'(4 * DEPTH), 32'h6666_6666, 3'b010, 0, 1'b0);
      do_txn(1'b0, 32'h2000, 32'd0, 3'b010, 0, 1'b0);
      do_txn(1'b0, 32'h2FFC, 32'd0, 3'b010, 0, 1'b0);
      do_txn(1'b0, 32'h2000, 32'd0, 3'b011, 0, 1'b0);
      do_txn(1'b1, 32'h2000, 32'h7777_7777, 3'b100, 0, 1'b0);
      do_txn(1'b0, 32'h2000, 32'd0, 3'b010, 0, 1'b0);

      do_txn(1'b0, 32'h2000, 32'd0, 3'b010, 5, 1'b0);
      do_txn(1'b0, 32'h2001, 32'd0, 3'b001, 0, 1'b0);
      do_txn(1'b0, 32'h2002, 32'd0, 3'b010, 0, 1'b0);

      do_txn(1'b1, 32'h2010, 32'hCAFE_F00D, 3'b010, 0, 1'b0);
      store_then_reset(32'h2010, 32'h1234_5678, 0);
      do_txn(1'b0, 32'h2010, 32'd0, 3'b010, 0, 1'b0);
      store_then_reset(32'h2010, 32'h8765_4321, 1);
      do_txn(1'b0, 32'h2010, 32'd0, 3'b010, 0, 1'b0);

      for (int k = 0; k < 8; k++) begin
         idx = $urandom_range(0, 15);
         wd  = $urandom;
         do_txn(1'b1, BASE + 32'(idx * 4), wd, 3'b010, 0, 1'b0);
         do_txn(1'b0, BASE + 32'(idx * 4) + 32'($urandom_range(0, 3)), 32'd0,
                size_tab[$urandom_range(0, 4)], 0, 1'b0);
      end

      $display("%0d/%0d checks passed", n_pass, n_chk);
      $finish;
   end
endmodule
